rtx_scheduler: RTL and testbench

- Frame-level scheduler that shares one pixel raster among `NUM_CORES` parallel ray-tracer cores.
- Walks pixel coordinates in raster order and issues each pixel to an idle core, using round-robin selection.
- Tracks which cores have work in flight and signals frame completion once every issued ray has returned.
- Sits between the top-level rtx control and the replicated ray_caster/ray_tracer lanes, replacing the single-lane `new_ray` retrigger loop.

---
 rtl/rtx_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_rtx_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtx_scheduler.sv
// rtx_scheduler: frame-level pixel scheduler for NUM_CORES parallel tracer cores.
// Walks the raster in row order and hands each pixel to an idle, ready core,
// picked round-robin. It tracks the cores that hold work and pulses frame_done
// once every issued ray has come back.
// Optional feature macro: RTX_SCHED_ABORT_EN adds a frame_abort input that ends
// issuing early and lets the outstanding rays drain.
module rtx_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_CORES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic [NUM_CORES-1:0]           core_ready,
  input  logic [NUM_CORES-1:0]           core_done,
`ifdef RTX_SCHED_ABORT_EN
  input  logic                           frame_abort,
`endif
  output logic [NUM_CORES-1:0]           issue_valid,
  output logic [10:0]                    issue_h,
  output logic [9:0]                     issue_v,
  output logic [$clog2(NUM_CORES+1)-1:0] in_flight,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int PW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IFW = $clog2(NUM_CORES + 1);
  localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
  localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_CORES-1:0]   busy_mask_q, busy_mask_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [10:0]            h_q, h_d;
  logic [9:0]             v_q, v_d;
  logic [NUM_CORES-1:0]   issue_valid_q;
  logic [10:0]            issue_h_q;
  logic [9:0]             issue_v_q;
  logic [IFW-1:0]         in_flight_q;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;

  logic                   abort_s;
  logic [NUM_CORES-1:0]   eligible_s;
  logic [NUM_CORES-1:0]   sel_onehot_s;
  logic [PW-1:0]          sel_idx_s;
  logic                   found_s;
  logic                   issue_s;
  logic [NUM_CORES-1:0]   grant_s;
  logic                   last_pixel_s;

  // Number of set bits in the busy mask.
  function automatic logic [IFW-1:0] popcount(input logic [NUM_CORES-1:0] m);
    logic [IFW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n = n + IFW'(m[i]);
    end
    return n;
  endfunction

`ifdef RTX_SCHED_ABORT_EN
  assign abort_s = frame_abort;
`else
  assign abort_s = 1'b0;
`endif

  // Round-robin pick: first eligible core at or above rr_ptr, else the lowest one below it.
  // A done arriving on this edge frees its core for selection on the same edge.
  always_comb begin
    eligible_s   = core_ready & ~(busy_mask_q & ~core_done);
    sel_idx_s    = '0;
    found_s      = 1'b0;
    sel_onehot_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found_s && eligible_s[i] && (i >= int'(rr_ptr_q))) begin
        found_s   = 1'b1;
        sel_idx_s = PW'(i);
      end else begin
        found_s   = found_s;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found_s && eligible_s[i]) begin
        found_s   = 1'b1;
        sel_idx_s = PW'(i);
      end else begin
        found_s   = found_s;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      sel_onehot_s[i] = found_s && (sel_idx_s == PW'(i));
    end
    issue_s      = (state_q == S_RUN) && !abort_s && found_s;
    grant_s      = issue_s ? sel_onehot_s : '0;
    last_pixel_s = (h_q == H_LAST) && (v_q == V_LAST);
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_RUN;
        else             state_d = S_IDLE;
      end
      S_RUN: begin
        if (abort_s)                      state_d = S_DRAIN;
        else if (issue_s && last_pixel_s) state_d = S_DRAIN;
        else                              state_d = S_RUN;
      end
      S_DRAIN: begin
        if (busy_mask_q == '0) state_d = S_DONE;
        else                   state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, computed from the upcoming state so they register in step with it.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_q == S_DRAIN) && (state_d == S_DONE);
  end

  // Busy mask, raster position and round-robin pointer updates.
  always_comb begin
    busy_mask_d = (busy_mask_q & ~core_done) | grant_s;
    h_d         = h_q;
    v_d         = v_q;
    rr_ptr_d    = rr_ptr_q;
    if ((state_q == S_IDLE) && frame_start) begin
      h_d      = 11'd0;
      v_d      = 10'd0;
      rr_ptr_d = '0;
    end else if (issue_s) begin
      if (h_q == H_LAST) begin
        h_d = 11'd0;
        v_d = v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
      if (sel_idx_s == PW'(NUM_CORES - 1)) rr_ptr_d = '0;
      else                                 rr_ptr_d = sel_idx_s + PW'(1);
    end else begin
      h_d = h_q;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask_q   <= '0;
      rr_ptr_q      <= '0;
      h_q           <= 11'd0;
      v_q           <= 10'd0;
      issue_valid_q <= '0;
      issue_h_q     <= 11'd0;
      issue_v_q     <= 10'd0;
      in_flight_q   <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      busy_mask_q   <= busy_mask_d;
      rr_ptr_q      <= rr_ptr_d;
      h_q           <= h_d;
      v_q           <= v_d;
      issue_valid_q <= grant_s;
      if (issue_s) begin
        issue_h_q <= h_q;
        issue_v_q <= v_q;
      end
      in_flight_q   <= popcount(busy_mask_d);
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_h     = issue_h_q;
  assign issue_v     = issue_v_q;
  assign in_flight   = in_flight_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_rtx_scheduler.sv
// Bench for rtx_scheduler with a 4x2 raster and two cores: a cycle table for a
// full frame plus reactive-core sequences for the multi-cycle corner cases.
module tb_rtx_scheduler;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [1:0] core_ready = 2'b00;
  logic [1:0] core_done = 2'b00;
`ifdef RTX_SCHED_ABORT_EN
  logic       frame_abort = 1'b0;
`endif
  logic [1:0]  issue_valid;
  logic [10:0] issue_h;
  logic [9:0]  issue_v;
  logic [1:0]  in_flight;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rtx_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .core_ready  (core_ready),
    .core_done   (core_done),
`ifdef RTX_SCHED_ABORT_EN
    .frame_abort (frame_abort),
`endif
    .issue_valid (issue_valid),
    .issue_h     (issue_h),
    .issue_v     (issue_v),
    .in_flight   (in_flight),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic       fs;
    logic [1:0] rdy;
    logic [1:0] dn;
    logic [1:0] iv;
    int         h;
    int         v;
    int         inf;
    logic       bsy;
    logic       fd;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_issue_valid"}, int'(issue_valid), 0);
    chk({tag, "_issue_h"}, int'(issue_h), 0);
    chk({tag, "_issue_v"}, int'(issue_v), 0);
    chk({tag, "_in_flight"}, int'(in_flight), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Runs one frame against a reactive core model: each issued core returns its
  // done lat edges after the issue edge. Optional: a stray frame_start at cycle
  // dup_at, a reset after reset_after issues, an abort after abort_after issues.
  task automatic run_frame(input logic [1:0] rdy, input int lat, input int dup_at,
                           input int reset_after, input int abort_after, input int exp_issues);
    int cnt[2];
    logic [1:0] outst;
    logic [1:0] dv;
    int issues, exph, expv, fd_seen, last_done, idx;
    logic abort_pend, aborted, stop;
    cnt[0] = 0; cnt[1] = 0;
    outst = 2'b00; issues = 0; exph = 0; expv = 0; fd_seen = 0; last_done = 0;
    abort_pend = 1'b0; aborted = 1'b0; stop = 1'b0;
    core_ready  = rdy;
    core_done   = 2'b00;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("start_busy", int'(busy), 1);
    for (int c = 1; c < 200 && !stop; c++) begin
      dv = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) dv[i] = 1'b1;
        end
      end
      core_done   = dv;
      frame_start = (c == dup_at);
`ifdef RTX_SCHED_ABORT_EN
      frame_abort = abort_pend;
      if (abort_pend) aborted = 1'b1;
      abort_pend = 1'b0;
`endif
      step();
      if (dv != 2'b00) last_done = c;
      outst = outst & ~dv;
      if (issue_valid != 2'b00) begin
        idx = issue_valid[1] ? 1 : 0;
        chk("issue_onehot", $countones(issue_valid), 1);
        chk("issue_core_ready", int'(rdy[idx]), 1);
        chk("issue_core_free", int'(outst[idx]), 0);
        chk("issue_after_abort", int'(aborted), 0);
        chk("issue_h", int'(issue_h), exph);
        chk("issue_v", int'(issue_v), expv);
        outst[idx] = 1'b1;
        cnt[idx] = lat;
        issues++;
        if (exph == W - 1) begin
          exph = 0;
          expv++;
        end else begin
          exph++;
        end
        if (abort_after > 0 && issues == abort_after) abort_pend = 1'b1;
      end
      chk("in_flight", int'(in_flight), int'(outst[0]) + int'(outst[1]));
      if (reset_after > 0 && issues == reset_after) begin
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        step();
        rst = 1'b0;
        core_done = 2'b11;
        step();
        chk("late_done_in_flight", int'(in_flight), 0);
        chk("late_done_busy", int'(busy), 0);
        core_done = 2'b00;
        stop = 1'b1;
      end else if (frame_done) begin
        fd_seen++;
        chk("fd_after_last_done", c, last_done + 1);
        chk("issue_count", issues, exp_issues);
        chk("fd_all_returned", int'(outst), 0);
        chk("fd_busy", int'(busy), 1);
        core_done = 2'b00;
        step();
        chk("post_fd_busy", int'(busy), 0);
        chk("post_fd_pulse", int'(frame_done), 0);
        stop = 1'b1;
      end
    end
    core_done   = 2'b00;
    frame_start = 1'b0;
`ifdef RTX_SCHED_ABORT_EN
    frame_abort = 1'b0;
`endif
    if (reset_after == 0) chk("frame_done_count", fd_seen, 1);
    step();
  endtask

  initial begin
    // Full frame, both cores ready, each done 3 edges after its issue edge.
    vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 2'b01, 0, 0, 1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 2'b00, 2'b10, 1, 0, 2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 2, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'b11, 2'b01, 2'b01, 2, 0, 2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 2'b11, 2'b10, 2'b10, 3, 0, 2, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 2'b11, 2'b01, 2'b01, 0, 1, 2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 2'b10, 2'b10, 1, 1, 2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'b11, 2'b01, 2'b01, 2, 1, 2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'b11, 2'b10, 2'b10, 3, 1, 2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'b11, 2'b01, 2'b00, 0, 0, 1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'b11, 2'b10, 2'b00, 0, 0, 0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_busy", int'(busy), 0);

    for (int r = 0; r < 17; r++) begin
      frame_start = vecs[r].fs;
      core_ready  = vecs[r].rdy;
      core_done   = vecs[r].dn;
      step();
      chk($sformatf("vec%0d_issue_valid", r), int'(issue_valid), int'(vecs[r].iv));
      if (vecs[r].iv != 2'b00) begin
        chk($sformatf("vec%0d_issue_h", r), int'(issue_h), vecs[r].h);
        chk($sformatf("vec%0d_issue_v", r), int'(issue_v), vecs[r].v);
      end
      chk($sformatf("vec%0d_in_flight", r), int'(in_flight), vecs[r].inf);
      chk($sformatf("vec%0d_busy", r), int'(busy), int'(vecs[r].bsy));
      chk($sformatf("vec%0d_frame_done", r), int'(frame_done), int'(vecs[r].fd));
    end
    frame_start = 1'b0;
    core_done   = 2'b00;
    step();

    // Core 1 never ready: every pixel goes to core 0, done and re-issue share an edge.
    run_frame(2'b01, 3, 0, 0, 0, 8);

    // Stray done while idle, then a frame_start pulse in the middle of RUN.
    core_done = 2'b10;
    step();
    chk("idle_spurious_in_flight", int'(in_flight), 0);
    chk("idle_spurious_busy", int'(busy), 0);
    core_done = 2'b00;
    step();
    run_frame(2'b11, 3, 3, 0, 0, 8);

    // Reset after three issues, then a fresh frame starting at (0,0).
    run_frame(2'b11, 2, 0, 3, 0, 8);
    run_frame(2'b11, 3, 0, 0, 0, 8);

`ifdef RTX_SCHED_ABORT_EN
    // Abort right after the second issue; both outstanding rays drain.
    run_frame(2'b11, 4, 0, 0, 2, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
